// File: rtl/banked_mem_pkg.sv
// Shared types, constants and address-split helpers for the banked word memory.
package banked_mem_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   localparam int unsigned BYTE_W = 8;

   // Bank field sits directly above the row field in a word address.
   function automatic int unsigned bank_of(input int unsigned addr, input int unsigned row_bits);
      return addr >> row_bits;
   endfunction

   function automatic int unsigned row_of(input int unsigned addr, input int unsigned row_bits);
      return addr & ((32'd1 << row_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/mem_lane.sv
// One byte lane of one bank: synchronous write, asynchronous read array.
module mem_lane
   import banked_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned RW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [RW-1:0]     i_waddr,
   input  logic [BYTE_W-1:0] i_wdata,
   input  logic [RW-1:0]     i_raddr,
   output logic [BYTE_W-1:0] o_rdata_c
);

   logic [BYTE_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/banked_mem.sv
// Banked word memory with byte enables, registered read port and a
// zero-fill sequencer that runs after reset and on clr.
module banked_mem
   import banked_mem_pkg::*;
#(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned NBANKS = 4,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned AW     = $clog2(NBANKS) + $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic                     we,
   input  logic [AW-1:0]            addr,
   input  logic [NBYTES-1:0]        be,
   input  logic [BYTE_W*NBYTES-1:0] wdata,
   input  logic                     clr,
   output logic                     ready,
   output logic [BYTE_W*NBYTES-1:0] rdata,
   output logic                     rvalid
);

   localparam int unsigned BW = $clog2(NBANKS);
   localparam int unsigned RW = $clog2(DEPTH);

   state_e          r_state;
   logic [RW-1:0]   r_cnt;

   logic            w_clear;
   logic            w_wr_acc;
   logic            w_rd_acc;
   logic [BW-1:0]   w_bank;
   logic [RW-1:0]   w_row;
   logic [RW-1:0]   w_waddr;
   logic [NBANKS-1:0][NBYTES-1:0][BYTE_W-1:0] w_lane_rd;

   assign w_bank   = BW'(bank_of(32'(addr), RW));
   assign w_row    = RW'(row_of(32'(addr), RW));
   assign w_clear  = (r_state == ST_CLEAR);
   assign ready    = !w_clear && !clr;
   assign w_wr_acc = req && ready && we;
   assign w_rd_acc = req && ready && !we;
   assign w_waddr  = w_clear ? r_cnt : w_row;

   // Every lane writes zero while clearing; otherwise only enabled lanes of the hit bank.
   for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
      for (genvar gl = 0; gl < NBYTES; gl++) begin : g_lane
         logic              w_we;
         logic [BYTE_W-1:0] w_wd;

         assign w_we = w_clear || (w_wr_acc && (w_bank == BW'(gb)) && be[gl]);
         assign w_wd = w_clear ? '0 : wdata[gl*BYTE_W +: BYTE_W];

         mem_lane #(
            .DEPTH (DEPTH),
            .RW    (RW)
         ) u_lane (
            .clk       (clk),
            .i_we      (w_we),
            .i_waddr   (w_waddr),
            .i_wdata   (w_wd),
            .i_raddr   (w_row),
            .o_rdata_c (w_lane_rd[gb][gl])
         );
      end
   end

   // Clear sequencer plus the registered read port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
         rvalid  <= 1'b0;
         rdata   <= '0;
      end else begin
         rvalid <= w_rd_acc;
         if (w_rd_acc) begin
            rdata <= w_lane_rd[w_bank];
         end
         case (r_state)
            ST_CLEAR: begin
               if (r_cnt == RW'(DEPTH - 1)) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + RW'(1);
               end
            end
            ST_IDLE: begin
               if (clr) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_banked_mem.sv
// Randomised and directed checks of banked_mem against a word-array model.
module tb_banked_mem;

   localparam int unsigned NB = 4;
   localparam int unsigned DP = 64;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req, we, clr;
   logic [7:0]  addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ready, rvalid;
   logic [31:0] rdata;

   logic        rst2, req2, we2, clr2;
   logic [6:0]  addr2;
   logic [1:0]  be2;
   logic [15:0] wdata2;
   logic        ready2, rvalid2;
   logic [15:0] rdata2;

   banked_mem dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
      .wdata(wdata), .clr(clr), .ready(ready), .rdata(rdata), .rvalid(rvalid)
   );

   banked_mem #(.NBYTES(2), .NBANKS(8), .DEPTH(16)) dut2 (
      .clk(clk), .rst(rst2), .req(req2), .we(we2), .addr(addr2), .be(be2),
      .wdata(wdata2), .clr(clr2), .ready(ready2), .rdata(rdata2), .rvalid(rvalid2)
   );

   // Model: memory is a plain word array that becomes all-zero when a clear finishes.
   logic [31:0] m_mem [256];
   int unsigned m_clear_left;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        m_ready;

   assign m_ready = (m_clear_left == 0) && !clr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_clear_left <= DP;
         m_rvalid     <= 1'b0;
         m_rdata      <= '0;
      end else begin
         m_rvalid <= 1'b0;
         if (m_clear_left != 0) begin
            m_clear_left <= m_clear_left - 1;
            if (m_clear_left == 1) begin
               for (int i = 0; i < 256; i++) m_mem[i] <= '0;
            end
         end else if (clr) begin
            m_clear_left <= DP;
         end else if (req) begin
            if (we) begin
               for (int i = 0; i < NB; i++) begin
                  if (be[i]) m_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end else begin
               m_rvalid <= 1'b1;
               m_rdata  <= m_mem[addr];
            end
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Compare all outputs with the model mid-cycle, then advance to just after the next edge.
   task automatic tick();
      @(negedge clk);
      chk("ready",  32'(ready),  32'(m_ready));
      chk("rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("rdata",  rdata,       m_rdata);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [7:0] a,
                        input logic [3:0] b, input logic [31:0] d, input logic c);
      req = r; we = w; addr = a; be = b; wdata = d; clr = c;
   endtask

   task automatic op(input logic r, input logic w, input logic [7:0] a,
                     input logic [3:0] b, input logic [31:0] d, input logic c);
      drive(r, w, a, b, d, c);
      tick();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic wait_ready(input string nm, input int exp_n);
      int n;
      n = 0;
      while (!ready && n < 1000) begin
         tick();
         n++;
      end
      chk(nm, 32'(n), 32'(exp_n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      rst2 = 1'b1;
      idle();
      req2 = 1'b0; we2 = 1'b0; addr2 = '0; be2 = '0; wdata2 = '0; clr2 = 1'b0;
      @(posedge clk);
      #1;
      tick();
      tick();
      chk("rst_ready",  32'(ready),  32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata",  rdata,       32'h0);

      rst = 1'b0;
      wait_ready("rst_clear_len", 64);

      for (int a = 0; a < 256; a++) op(1'b1, 1'b0, 8'(a), 4'hF, 32'hFFFF_FFFF, 1'b0);
      idle();
      chk("zero_rd", rdata, 32'h0);
      chk("zero_rv", 32'(rvalid), 32'h1);
      tick();

      op(1'b1, 1'b1, 8'h00, 4'hF, 32'hDEAD_BEEF, 1'b0);
      op(1'b1, 1'b1, 8'hC0, 4'h5, 32'h1234_5678, 1'b0);
      op(1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0);
      chk("rd_00", rdata, 32'hDEAD_BEEF);
      op(1'b1, 1'b0, 8'hC0, 4'h0, 32'h0, 1'b0);
      chk("rd_c0_be", rdata, 32'h0034_0078);

      op(1'b1, 1'b1, 8'h41, 4'hF, 32'hA5A5_A5A5, 1'b0);
      op(1'b1, 1'b0, 8'h41, 4'h0, 32'h0, 1'b0);
      chk("raw_41", rdata, 32'hA5A5_A5A5);

      op(1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0);
      chk("b2b_0", rdata, 32'hDEAD_BEEF);
      op(1'b1, 1'b0, 8'h41, 4'h0, 32'h0, 1'b0);
      chk("b2b_1", rdata, 32'hA5A5_A5A5);
      op(1'b1, 1'b0, 8'hC0, 4'h0, 32'h0, 1'b0);
      chk("b2b_2", rdata, 32'h0034_0078);
      chk("b2b_rv", 32'(rvalid), 32'h1);
      idle();
      tick();

      // Reset while a read result is being presented.
      op(1'b1, 1'b0, 8'h41, 4'h0, 32'h0, 1'b0);
      idle();
      rst = 1'b1;
      #1;
      chk("arst_ready",  32'(ready),  32'h0);
      chk("arst_rvalid", 32'(rvalid), 32'h0);
      chk("arst_rdata",  rdata,       32'h0);
      tick();
      rst = 1'b0;
      wait_ready("rst_op_clear_len", 64);
      op(1'b1, 1'b0, 8'h41, 4'h0, 32'h0, 1'b0);
      chk("post_rst_41", rdata, 32'h0);

      repeat (2000) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))},
               4'($urandom), $urandom, 1'($urandom_range(0, 299) == 0));
         tick();
      end
      idle();
      n = 0;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
      chk("rand_settle", 32'(ready), 32'h1);

      // clr beats a simultaneous write.
      op(1'b1, 1'b1, 8'h10, 4'hF, 32'hFFFF_FFFF, 1'b0);
      drive(1'b1, 1'b1, 8'h10, 4'hF, 32'hCAFE_F00D, 1'b1);
      #1;
      chk("clr_ready_low", 32'(ready), 32'h0);
      tick();
      idle();
      wait_ready("clr_len", 64);
      op(1'b1, 1'b0, 8'h10, 4'h0, 32'h0, 1'b0);
      chk("clr_rd_10", rdata, 32'h0);
      op(1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 1'b0);
      chk("clr_rd_00", rdata, 32'h0);

      // Reset part-way through a clr-triggered clear.
      op(1'b1, 1'b1, 8'h41, 4'hF, 32'hA5A5_A5A5, 1'b0);
      op(1'b1, 1'b0, 8'h41, 4'h0, 32'h0, 1'b0);
      op(1'b0, 1'b0, 8'h00, 4'h0, 32'h0, 1'b1);
      idle();
      repeat (30) tick();
      chk("pre_rst30_rdata", rdata, 32'hA5A5_A5A5);
      rst = 1'b1;
      #1;
      chk("rst30_ready",  32'(ready),  32'h0);
      chk("rst30_rvalid", 32'(rvalid), 32'h0);
      chk("rst30_rdata",  rdata,       32'h0);
      tick();
      rst = 1'b0;
      wait_ready("rst30_clear_len", 64);

      // Second geometry: 2 lanes, 8 banks, 16 rows.
      rst2 = 1'b0;
      n = 0;
      while (!ready2 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("p2_clear_len", 32'(n), 32'd16);
      req2 = 1'b1; we2 = 1'b1; addr2 = 7'h7F; be2 = 2'b10; wdata2 = 16'hBEEF;
      @(posedge clk);
      #1;
      addr2 = 7'h0F; be2 = 2'b11; wdata2 = 16'h1234;
      @(posedge clk);
      #1;
      we2 = 1'b0; addr2 = 7'h7F;
      @(posedge clk);
      #1;
      req2 = 1'b0;
      chk("p2_rd_7f", 32'(rdata2), 32'h0000_BE00);
      chk("p2_rv",    32'(rvalid2), 32'h1);
      @(posedge clk);
      #1;
      chk("p2_rv_drop", 32'(rvalid2), 32'h0);
      chk("p2_rd_hold", 32'(rdata2), 32'h0000_BE00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/banked_mem.md
# banked_mem

Parametrised banked word memory with per-byte write enables, a one-cycle registered read port and a built-in zero-initialisation sequencer. It generalises the fixed 4-bank × 4-lane, 32-bit, 256-word store: bank selection comes from the upper address bits, and byte lanes are individually writable. A single muxed read path replaces the tri-state output bus. Requesters use a req/ready handshake and must not issue accesses until the clear sequence completes.

## Interface
- NBYTES, 4: byte lanes per word; data width is 8*NBYTES
- NBANKS, 4: number of banks; power of two, ≥ 2
- DEPTH, 64: words per bank; power of two, ≥ 2
- AW, derived, $clog2(NBANKS)+$clog2(DEPTH): address width (8 by default)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request
- we  in  1  1 = write, 0 = read; qualified by req
- addr  in  AW  word address; bank = addr[AW-1 -: log2 NBANKS], row = low log2(DEPTH) bits
- be  in  NBYTES  byte write enables, writes only
- wdata  in  8*NBYTES  write data
- clr  in  1  request re-zeroing of the whole memory
- ready  out  1  access accepted this cycle when req & ready
- rdata  out  8*NBYTES  read data
- rvalid  out  1  rdata holds the result of the read accepted on the previous edge

## Operation
- FSM states:
  - CLEAR: row counter cnt walks 0..DEPTH-1 and writes zero to row cnt in every bank and lane, one row per cycle. After row DEPTH-1 is written the FSM moves to IDLE.
  - IDLE: services accesses. clr=1 moves the FSM to CLEAR with cnt=0.
- ready = (state==IDLE) & !clr, combinational. clr has priority: a req in the same cycle as clr is not accepted.
- Write (req & ready & we): every lane i with be[i]=1 in the addressed bank/row takes wdata[8i+7:8i] at the edge. Lanes with be[i]=0 are unchanged. be=0 is a legal no-op. Other banks are untouched.
- Read (req & ready & !we): at the edge, rdata is loaded with the addressed word and rvalid=1 for the following cycle. be and wdata are ignored.
- Cycles with no read accepted: rvalid=0 and rdata holds its last value.
- Back-to-back reads give one result per cycle.
- A read accepted the cycle after a write to the same address returns the newly written bytes.
- Address arithmetic has no wrap and no out-of-range case: every AW-bit address maps to exactly one word.

## Timing
- Reset values: state=CLEAR, cnt=0, ready=0, rvalid=0, rdata=0. Memory contents are undefined until the clear completes.
- After rst deasserts, edges 1..DEPTH clear rows 0..DEPTH-1. ready rises after edge DEPTH, i.e. DEPTH cycles (64 by default).
- rst asserted mid-clear or mid-operation: the FSM returns to CLEAR with cnt=0 immediately and rvalid drops immediately. The full clear reruns after release.
- A clr-triggered clear also takes DEPTH cycles with ready=0. A read accepted on the edge where clr is sampled cannot occur (ready=0 that cycle). A read accepted on the previous edge still presents its rvalid.
- clr asserted during CLEAR is ignored; it does not restart the counter.
- Read latency is 1 cycle from the accepting edge. Write is visible to reads accepted on the next edge.

## Structure
- Package banked_mem_pkg holds:
  - the state enum (CLEAR, IDLE)
  - the byte width constant 8
  - helper functions for the bank/row address split
- Sub-module mem_lane is natural: one 8-bit × DEPTH synchronous-write array with a write enable. It is instantiated NBANKS×NBYTES times. The write enable is the OR of clear-mode and (bank hit & be[i] & write accept). The write data is 0 in CLEAR, otherwise the wdata byte.
- The read mux selects the bank by the bank field and sits before the rdata register.

## Test plan
- Release reset, hold req=0: ready=0 for exactly 64 cycles, then 1. Read every address: each rdata=0x00000000 with rvalid one cycle after the request.
- Write addr 0x00 wdata 0xDEADBEEF be=1111, then write addr 0xC0 wdata 0x12345678 be=0101. Read 0x00 → 0xDEADBEEF; read 0xC0 → 0x00340078. Bank 3 writes do not alias bank 0.
- Write 0x41 = 0xA5A5A5A5, then read 0x41 on the next cycle → 0xA5A5A5A5. Three back-to-back reads 0x00, 0x41, 0xC0 → rvalid high three cycles with the data in order.
- Assert clr with req=1 & we=1 to 0x10: the write is not performed and ready=0 for 64 cycles. Afterwards 0x00 reads 0.
- Assert rst at cleared-row 30: ready, rvalid and rdata go 0 asynchronously. After release, ready rises only after a full 64-cycle clear.
- Parameter sweep NBYTES=2, NBANKS=8, DEPTH=16: AW=7, clear=16 cycles. be=10 write of 0xBEEF to addr 0x7F then read → 0xBE00.
